// File: rtl/dfi_datapath_sched.sv
// DFI write/read data buffering with programmable write-latency launch and read-slot credit tracking.
// Optional write byte-mask storage is enabled by defining DFI_DATAPATH_WRMASK_EN.
module dfi_datapath_sched #(
  parameter int C_DFI_FREQ_RATIO = 2,
  parameter int C_DFI_DATA_WIDTH = 32,
  parameter int C_WFIFO_AW       = 4,
  parameter int C_RFIFO_AW       = 5,
  parameter int C_MAX_WRLAT      = 16
) (
  input  logic                                           core_clk,
  input  logic                                           core_arstn,
  input  logic [$clog2(C_MAX_WRLAT+1)-1:0]               cfg_wrlat,
  input  logic                                           w_wren,
  input  logic [C_DFI_FREQ_RATIO*C_DFI_DATA_WIDTH-1:0]   w_wdata,
`ifdef DFI_DATAPATH_WRMASK_EN
  input  logic [C_DFI_FREQ_RATIO*C_DFI_DATA_WIDTH/8-1:0] w_wmask,
`endif
  output logic                                           w_wfull,
  output logic                                           w_avail,
  input  logic                                           w_issue,
  output logic                                           dfi_wrdata_en,
  output logic [C_DFI_FREQ_RATIO*C_DFI_DATA_WIDTH-1:0]   dfi_wrdata,
  output logic [C_DFI_FREQ_RATIO*C_DFI_DATA_WIDTH/8-1:0] dfi_wrdata_mask,
  input  logic                                           r_reserve,
  output logic                                           r_credit,
  input  logic                                           dfi_rddata_valid,
  input  logic [C_DFI_FREQ_RATIO*C_DFI_DATA_WIDTH-1:0]   dfi_rddata,
  input  logic                                           r_rden,
  output logic [C_DFI_FREQ_RATIO*C_DFI_DATA_WIDTH-1:0]   r_rdata,
  output logic                                           r_rempty,
  output logic                                           err_underrun,
  output logic                                           err_overflow
);

  localparam int W      = C_DFI_FREQ_RATIO * C_DFI_DATA_WIDTH;
  localparam int MW     = W / 8;
  localparam int WDEPTH = 2 ** C_WFIFO_AW;
  localparam int RDEPTH = 2 ** C_RFIFO_AW;
  localparam int LW     = $clog2(C_MAX_WRLAT + 1);
  // Committed count covers every buffered word plus underrun launches still in flight.
  localparam int CW     = $clog2(WDEPTH + C_MAX_WRLAT + 1) + 1;
`ifdef DFI_DATAPATH_WRMASK_EN
  localparam int WE     = W + MW;
`else
  localparam int WE     = W;
`endif

  typedef logic [C_WFIFO_AW-1:0] wptr_t;
  typedef logic [C_WFIFO_AW:0]   wcnt_t;
  typedef logic [CW-1:0]         cmt_t;
  typedef logic [C_RFIFO_AW-1:0] rptr_t;
  typedef logic [C_RFIFO_AW:0]   rcnt_t;
  typedef logic [C_RFIFO_AW+1:0] rsum_t;
  typedef logic [LW-1:0]         lat_t;

  wptr_t wwr_ptr_q, wwr_ptr_d, wrd_ptr_q, wrd_ptr_d;
  wcnt_t wcount_q, wcount_d;
  cmt_t  committed_q, committed_d;
  logic [C_MAX_WRLAT-1:0] dl_q, dl_d;
  rptr_t rwr_ptr_q, rwr_ptr_d, rrd_ptr_q, rrd_ptr_d;
  rcnt_t rcount_q, rcount_d, rout_q, rout_d;
  logic  err_underrun_q, err_underrun_d, err_overflow_q, err_overflow_d;

  logic [WE-1:0] wmem [WDEPTH];
  logic [W-1:0]  rmem [RDEPTH];
  logic [WE-1:0] w_entry, w_head;

  lat_t lat_eff;
  logic launch, w_pop, w_push, r_valid_ok, r_reserve_ok, r_pop;

`ifdef DFI_DATAPATH_WRMASK_EN
  assign w_entry = {w_wmask, w_wdata};
`else
  assign w_entry = w_wdata;
`endif
  assign w_head = wmem[wrd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lat_eff = cfg_wrlat;
    if (cfg_wrlat == '0)                      lat_eff = lat_t'(1);
    else if (cfg_wrlat > lat_t'(C_MAX_WRLAT)) lat_eff = lat_t'(C_MAX_WRLAT);
    launch = 1'b0;
    for (int i = 0; i < C_MAX_WRLAT; i++) begin
      if (lat_eff == lat_t'(i + 1)) launch = dl_q[i];
    end
  end

  // A launch pops the head in its own cycle, which frees a slot for a same-cycle push.
  assign w_pop        = launch & (wcount_q != '0);
  assign w_push       = w_wren & (~w_wfull | w_pop);
  assign r_credit     = (rsum_t'(rcount_q) + rsum_t'(rout_q)) < rsum_t'(RDEPTH);
  assign r_reserve_ok = r_reserve & r_credit;
  assign r_valid_ok   = dfi_rddata_valid & (rout_q != '0);
  assign r_pop        = r_rden & ~r_rempty;

  always_comb begin
    dl_d           = {dl_q[C_MAX_WRLAT-2:0], w_issue};
    wwr_ptr_d      = wwr_ptr_q + wptr_t'(w_push);
    wrd_ptr_d      = wrd_ptr_q + wptr_t'(w_pop);
    wcount_d       = wcount_q + wcnt_t'(w_push) - wcnt_t'(w_pop);
    committed_d    = committed_q + cmt_t'(w_issue) - cmt_t'(launch);
    err_underrun_d = err_underrun_q | (launch & (wcount_q == '0));
    rwr_ptr_d      = rwr_ptr_q + rptr_t'(r_valid_ok);
    rrd_ptr_d      = rrd_ptr_q + rptr_t'(r_pop);
    rcount_d       = rcount_q + rcnt_t'(r_valid_ok) - rcnt_t'(r_pop);
    rout_d         = rout_q + rcnt_t'(r_reserve_ok) - rcnt_t'(r_valid_ok);
    err_overflow_d = err_overflow_q | (dfi_rddata_valid & (rout_q == '0));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      dl_q           <= '0;
      wwr_ptr_q      <= '0;
      wrd_ptr_q      <= '0;
      wcount_q       <= '0;
      committed_q    <= '0;
      err_underrun_q <= 1'b0;
      rwr_ptr_q      <= '0;
      rrd_ptr_q      <= '0;
      rcount_q       <= '0;
      rout_q         <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      dl_q           <= dl_d;
      wwr_ptr_q      <= wwr_ptr_d;
      wrd_ptr_q      <= wrd_ptr_d;
      wcount_q       <= wcount_d;
      committed_q    <= committed_d;
      err_underrun_q <= err_underrun_d;
      rwr_ptr_q      <= rwr_ptr_d;
      rrd_ptr_q      <= rrd_ptr_d;
      rcount_q       <= rcount_d;
      rout_q         <= rout_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  // NOTE: storage arrays are not reset; the counters define validity and outputs are gated when empty.
  always_ff @(posedge core_clk) begin
    if (w_push)     wmem[wwr_ptr_q] <= w_entry;
    if (r_valid_ok) rmem[rwr_ptr_q] <= dfi_rddata;
  end

  assign w_wfull       = wcount_q == wcnt_t'(WDEPTH);
  assign w_avail       = cmt_t'(wcount_q) > committed_q;
  assign dfi_wrdata_en = launch;
  assign dfi_wrdata    = w_pop ? w_head[W-1:0] : '0;
`ifdef DFI_DATAPATH_WRMASK_EN
  assign dfi_wrdata_mask = w_pop ? w_head[WE-1:W] : '0;
`else
  assign dfi_wrdata_mask = '0;
`endif
  assign r_rempty      = rcount_q == '0;
  assign r_rdata       = r_rempty ? '0 : rmem[rrd_ptr_q];
  assign err_underrun  = err_underrun_q;
  assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_dfi_datapath_sched.sv
// Randomised self-checking bench for dfi_datapath_sched against a queue-based reference model.
module tb_dfi_datapath_sched;

  localparam int W = 64;
  localparam int MW = 8;

  logic          core_clk, core_arstn;
  logic [4:0]    cfg_wrlat;
  logic          w_wren, w_issue, r_reserve, dfi_rddata_valid, r_rden;
  logic [W-1:0]  w_wdata, dfi_rddata;
  logic [MW-1:0] w_wmask;
  logic          w_wfull, w_avail, dfi_wrdata_en, r_credit, r_rempty, err_underrun, err_overflow;
  logic [W-1:0]  dfi_wrdata, r_rdata;
  logic [MW-1:0] dfi_wrdata_mask;

  dfi_datapath_sched dut (
    .core_clk(core_clk), .core_arstn(core_arstn), .cfg_wrlat(cfg_wrlat),
    .w_wren(w_wren), .w_wdata(w_wdata),
`ifdef DFI_DATAPATH_WRMASK_EN
    .w_wmask(w_wmask),
`endif
    .w_wfull(w_wfull), .w_avail(w_avail), .w_issue(w_issue),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata), .dfi_wrdata_mask(dfi_wrdata_mask),
    .r_reserve(r_reserve), .r_credit(r_credit), .dfi_rddata_valid(dfi_rddata_valid),
    .dfi_rddata(dfi_rddata), .r_rden(r_rden), .r_rdata(r_rdata), .r_rempty(r_rempty),
    .err_underrun(err_underrun), .err_overflow(err_overflow)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  typedef struct {logic [W-1:0] d; logic [MW-1:0] m;} wword_t;
  wword_t       wq[$];
  longint       lq[$];
  logic [W-1:0] rq[$];
  int           m_committed, m_out;
  bit           m_err_u, m_err_o;
  longint       cyc;
  int           n_tests, n_fail;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int eff_lat();
    if (cfg_wrlat == 0) return 1;
    if (cfg_wrlat > 16) return 16;
    return int'(cfg_wrlat);
  endfunction

  task automatic check_outputs();
    bit en;
    en = (lq.size() > 0) && (lq[0] == cyc);
    check("wrdata_en", dfi_wrdata_en, en);
    check("wrdata", dfi_wrdata, (en && wq.size() > 0) ? wq[0].d : '0);
`ifdef DFI_DATAPATH_WRMASK_EN
    check("wrmask", dfi_wrdata_mask, (en && wq.size() > 0) ? wq[0].m : '0);
`else
    check("wrmask", dfi_wrdata_mask, '0);
`endif
    check("w_wfull", w_wfull, wq.size() == 16);
    if (m_committed <= wq.size()) check("w_avail", w_avail, wq.size() > m_committed);
    check("r_credit", r_credit, (rq.size() + m_out) < 32);
    check("r_rempty", r_rempty, rq.size() == 0);
    check("r_rdata", r_rdata, (rq.size() > 0) ? rq[0] : '0);
    check("err_underrun", err_underrun, m_err_u);
    check("err_overflow", err_overflow, m_err_o);
  endtask

  task automatic model_step();
    bit launch, popped, credit;
    int wsz, rsz;
    wsz = wq.size();
    launch = (lq.size() > 0) && (lq[0] == cyc);
    popped = 0;
    if (launch) begin
      void'(lq.pop_front());
      m_committed--;
      if (wsz > 0) begin
        void'(wq.pop_front());
        popped = 1;
      end else m_err_u = 1;
    end
    if (w_wren && (wsz < 16 || popped)) wq.push_back('{w_wdata, w_wmask});
    if (w_issue) begin
      lq.push_back(cyc + eff_lat());
      m_committed++;
    end
    rsz = rq.size();
    credit = (rsz + m_out) < 32;
    if (r_rden && rsz > 0) void'(rq.pop_front());
    if (dfi_rddata_valid) begin
      if (m_out > 0) begin
        rq.push_back(dfi_rddata);
        m_out--;
      end else m_err_o = 1;
    end
    if (r_reserve && credit) m_out++;
  endtask

  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge core_clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    w_wren = 0; w_issue = 0; r_reserve = 0; dfi_rddata_valid = 0; r_rden = 0;
    w_wdata = '0; w_wmask = '0; dfi_rddata = '0;
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    core_arstn = 0;
    wq.delete(); lq.delete(); rq.delete();
    m_committed = 0; m_out = 0; m_err_u = 0; m_err_o = 0;
    repeat (n) begin
      @(posedge core_clk);
      #1;
      cyc++;
    end
    check_outputs();
    core_arstn = 1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    cfg_wrlat = 5'd3;
    do_reset(3);

    // Single write launched at wrlat 3.
    w_wren = 1; w_wdata = 64'hA5A5_0001; w_wmask = 8'h3C;
    cycle();
    w_wren = 0; w_issue = 1;
    cycle();
    w_issue = 0;
    cycle();
    cycle();
    check("wrlat3_en", dfi_wrdata_en, 1'b1);
    check("wrlat3_data", dfi_wrdata, 64'hA5A5_0001);
    repeat (5) cycle();

    // Fill past capacity, then drain back to back.
    for (int i = 0; i < 17; i++) begin
      w_wren = 1; w_wdata = 64'h1000 + W'(i); w_wmask = MW'(i);
      cycle();
    end
    w_wren = 0;
    check("fill_full", w_wfull, 1'b1);
    w_issue = 1;
    repeat (16) cycle();
    w_issue = 0;
    repeat (20) cycle();
    check("drain_full", w_wfull, 1'b0);
    check("drain_avail", w_avail, 1'b0);

    // Underrun at wrlat 0.
    cfg_wrlat = 5'd0;
    w_issue = 1;
    cycle();
    w_issue = 0;
    check("underrun_en", dfi_wrdata_en, 1'b1);
    check("underrun_data", dfi_wrdata, '0);
    repeat (4) cycle();
    check("underrun_sticky", err_underrun, 1'b1);

    // Read credit exhaustion and in-order return.
    r_reserve = 1;
    repeat (33) cycle();
    r_reserve = 0;
    check("credit_zero", r_credit, 1'b0);
    for (int i = 0; i < 32; i++) begin
      dfi_rddata_valid = 1; dfi_rddata = {$urandom, $urandom};
      cycle();
    end
    dfi_rddata_valid = 0;
    r_rden = 1;
    repeat (32) cycle();
    r_rden = 0;
    cycle();
    check("rd_empty", r_rempty, 1'b1);
    check("rd_credit", r_credit, 1'b1);

    // Return with no reservation.
    dfi_rddata_valid = 1; dfi_rddata = 64'hDEAD_BEEF;
    cycle();
    dfi_rddata_valid = 0;
    cycle();
    check("overflow_err", err_overflow, 1'b1);
    check("overflow_empty", r_rempty, 1'b1);

    // Reset with two launches in flight.
    cfg_wrlat = 5'd5;
    w_wren = 1; w_wdata = 64'h77; cycle();
    w_wdata = 64'h88; cycle();
    w_wren = 0; w_issue = 1;
    repeat (2) cycle();
    w_issue = 0;
    cycle();
    core_arstn = 0;
    #1;
    check("async_rst_en", dfi_wrdata_en, 1'b0);
    check("async_rst_full", w_wfull, 1'b0);
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      check("post_rst_en", dfi_wrdata_en, 1'b0);
      cycle();
    end

    // Random traffic across several latency settings.
    for (int ph = 0; ph < 6; ph++) begin
      cfg_wrlat = 5'($urandom_range(0, 16));
      for (int i = 0; i < 400; i++) begin
        w_wren = $urandom_range(0, 1) == 1;
        w_wdata = {$urandom, $urandom};
        w_wmask = 8'($urandom);
        w_issue = (wq.size() > m_committed) && ($urandom_range(0, 2) == 0);
        r_reserve = $urandom_range(0, 1) == 1;
        dfi_rddata_valid = (m_out > 0) && ($urandom_range(0, 1) == 1);
        dfi_rddata = {$urandom, $urandom};
        r_rden = $urandom_range(0, 2) != 0;
        cycle();
      end
      idle_inputs();
      repeat (20) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
